// File: rtl/ds_run_sequencer.sv
// Run controller for the down-sample processor: issues start pulses for a batch of
// runs, times each run against the finished handshake, aborts on hang, snapshots debug.
module ds_run_sequencer #(
  parameter int DBG_W   = 16,
  parameter int CNT_W   = 24,
  parameter int RUNS_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              go,
  input  logic [RUNS_W-1:0] num_runs,
  output logic              proc_start,
  input  logic              proc_finished,
  input  logic [DBG_W-1:0]  dbg_in,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  total_cycles,
  output logic [RUNS_W-1:0] runs_done,
  output logic [DBG_W-1:0]  snapshot,
  output logic              snap_valid
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t            state;
  logic              fin_q;
  logic [CNT_W-1:0]  cnt;
  logic [RUNS_W-1:0] runs_q;
  logic [DBG_W-1:0]  dbg_q;
  logic              rise;
  logic [CNT_W:0]    sum;
  logic [RUNS_W-1:0] runs_next;

  assign rise      = proc_finished & ~fin_q;
  assign sum       = {1'b0, total_cycles} + {1'b0, cnt};
  assign runs_next = runs_done + 1'b1;

  // cnt equals the number of cycles elapsed since the start pulse cycle, so the
  // value held when a rise is sampled is exactly the run length.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fin_q        <= 1'b0;
      cnt          <= '0;
      runs_q       <= '0;
      dbg_q        <= '0;
      proc_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      cycles       <= '0;
      total_cycles <= '0;
      runs_done    <= '0;
      snapshot     <= '0;
      snap_valid   <= 1'b0;
    end else begin
      fin_q      <= proc_finished;
      proc_start <= 1'b0;
      done       <= 1'b0;
      snap_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            runs_q      <= num_runs;
            runs_done   <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b1;
            if (num_runs == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              total_cycles <= '0;
              state        <= START;
              proc_start   <= 1'b1;
            end
          end
        end
        START, WAIT: begin
          if (rise) begin
            dbg_q <= dbg_in;
            state <= CAPTURE;
          end else if (state == WAIT && cnt == TIMEOUT_CNT) begin
            timeout_err <= 1'b1;
            state       <= DONE;
            done        <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= WAIT;
          end
        end
        CAPTURE: begin
          cycles       <= cnt;
          snapshot     <= dbg_q;
          snap_valid   <= 1'b1;
          runs_done    <= runs_next;
          total_cycles <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
          if (runs_next < runs_q) begin
            state      <= START;
            proc_start <= 1'b1;
            cnt        <= '0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds_run_sequencer.sv
// Bench for ds_run_sequencer: a behavioural processor answers each start pulse after a
// chosen delay; a per-sequence run-level model predicts the resulting counters.
module tb_ds_run_sequencer;

  localparam int DBG_W   = 16;
  localparam int CNT_W   = 5;
  localparam int RUNS_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int SAT     = (1 << CNT_W) - 1;
  localparam int NEVER   = 100;

  logic              clock = 1'b0;
  logic              rst_n;
  logic              go;
  logic [RUNS_W-1:0] num_runs;
  logic              proc_start;
  logic              proc_finished;
  logic [DBG_W-1:0]  dbg_in;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic [CNT_W-1:0]  cycles;
  logic [CNT_W-1:0]  total_cycles;
  logic [RUNS_W-1:0] runs_done;
  logic [DBG_W-1:0]  snapshot;
  logic              snap_valid;

  ds_run_sequencer #(
    .DBG_W(DBG_W), .CNT_W(CNT_W), .RUNS_W(RUNS_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .rst_n(rst_n), .go(go), .num_runs(num_runs),
    .proc_start(proc_start), .proc_finished(proc_finished), .dbg_in(dbg_in),
    .busy(busy), .done(done), .timeout_err(timeout_err), .cycles(cycles),
    .total_cycles(total_cycles), .runs_done(runs_done), .snapshot(snapshot),
    .snap_valid(snap_valid)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int start_count, done_count, snap_count, width_err, start_idx, done_cyc, go_cyc;
  int countdown, run_id;
  bit armed = 1'b0;
  bit hold = 1'b0;
  bit prev_start = 1'b0;
  int cur_delay [8];
  logic [DBG_W-1:0] dbg_at [8];

  int m_cycles = 0;
  int m_total = 0;
  logic [DBG_W-1:0] m_snap = '0;

  // Processor stand-in and pulse monitor, all acting mid-cycle on the falling edge.
  initial begin
    proc_finished = 1'b0;
    dbg_in = '0;
    forever begin
      @(negedge clock);
      cyc++;
      dbg_in = DBG_W'($urandom);
      if (hold) proc_finished = 1'b1;
      else if (proc_finished) proc_finished = 1'b0;
      if (!busy) armed = 1'b0;
      if (armed) begin
        if (countdown == 1) begin
          if (!hold) proc_finished = 1'b1;
          dbg_at[run_id] = dbg_in;
          armed = 1'b0;
        end else countdown--;
      end
      if (proc_start) begin
        if (prev_start) width_err++;
        start_count++;
        if (start_idx < 8) begin
          if (cur_delay[start_idx] == 0) begin
            if (!hold) proc_finished = 1'b1;
            dbg_at[start_idx] = dbg_in;
          end else begin
            armed = 1'b1;
            countdown = cur_delay[start_idx];
            run_id = start_idx;
          end
        end
        start_idx++;
      end
      prev_start = proc_start;
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (snap_valid) snap_count++;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clear_monitor();
    start_idx = 0;
    start_count = 0;
    done_count = 0;
    snap_count = 0;
    width_err = 0;
    done_cyc = -1;
  endtask

  task automatic apply_stimulus(input int n, input int d0, input int d1, input int d2,
                                input int d3, input bit poke);
    int waited;
    cur_delay[0] = d0; cur_delay[1] = d1; cur_delay[2] = d2; cur_delay[3] = d3;
    for (int i = 4; i < 8; i++) cur_delay[i] = NEVER;
    clear_monitor();
    @(negedge clock); #1;
    go = 1'b1;
    num_runs = RUNS_W'(n);
    go_cyc = cyc;
    @(negedge clock); #1;
    go = 1'b0;
    num_runs = RUNS_W'($urandom_range(1, 200));
    waited = 0;
    while (done_count == 0 && waited < 2000) begin
      @(negedge clock); #1;
      waited++;
      if (poke && busy && waited == 3) begin
        go = 1'b1;
        num_runs = RUNS_W'($urandom_range(1, 200));
        @(negedge clock); #1;
        waited++;
        go = 1'b0;
      end
    end
    repeat (3) @(negedge clock);
    #1;
  endtask

  // Run-level reference: walk the runs, each one either completing after its delay
  // or hanging past TIMEOUT, and derive counters and the cycle of the done pulse.
  task automatic model_check(input int n, input int d0, input int d1, input int d2,
                             input int d3);
    int dl [4];
    int succ, to, t, exp_done, d;
    dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
    succ = 0; to = 0;
    t = go_cyc + 1;
    exp_done = go_cyc + 1;
    if (n > 0) m_total = 0;
    for (int i = 0; i < n; i++) begin
      d = (i < 4) ? dl[i] : NEVER;
      if (d > TIMEOUT) begin
        to = 1;
        exp_done = t + TIMEOUT + 1;
        break;
      end
      succ++;
      m_cycles = d;
      m_total = (m_total + d > SAT) ? SAT : m_total + d;
      m_snap = dbg_at[i];
      t = t + d + 2;
      exp_done = t;
    end
    check_output("runs_done", 32'(runs_done), 32'(succ));
    check_output("cycles", 32'(cycles), 32'(m_cycles));
    check_output("total_cycles", 32'(total_cycles), 32'(m_total));
    check_output("timeout_err", 32'(timeout_err), 32'(to));
    check_output("snapshot", 32'(snapshot), 32'(m_snap));
    check_output("start_pulses", 32'(start_count), 32'(succ + to));
    check_output("snap_pulses", 32'(snap_count), 32'(succ));
    check_output("done_pulses", 32'(done_count), 32'd1);
    check_output("done_cycle", 32'(done_cyc), 32'(exp_done));
    check_output("start_width", 32'(width_err), 32'd0);
    check_output("busy_after", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int n;
    int d0, d1, d2, d3;
    bit poke;
    int e_runs, e_cycles, e_total;
    bit e_to;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1, 10, 0, 0, 0, 1'b0, 1, 10, 10, 1'b0};
    vecs[1] = '{3, 5, 7, 9, 0, 1'b0, 3, 9, 21, 1'b0};
    vecs[2] = '{1, NEVER, 0, 0, 0, 1'b0, 0, 9, 0, 1'b1};
    vecs[3] = '{1, 16, 0, 0, 0, 1'b0, 1, 16, 16, 1'b0};
    vecs[4] = '{2, 16, 16, 0, 0, 1'b0, 2, 16, 31, 1'b0};
    vecs[5] = '{2, 0, 3, 0, 0, 1'b1, 2, 3, 3, 1'b0};
    vecs[6] = '{3, 4, 17, 5, 0, 1'b1, 1, 4, 4, 1'b1};
    vecs[7] = '{0, 0, 0, 0, 0, 1'b0, 0, 4, 4, 1'b0};

    go = 1'b0;
    num_runs = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_outputs",
                 32'({proc_start, done, timeout_err, snap_valid, cycles, total_cycles}), 32'd0);
    check_output("reset_runs_snap", 32'({runs_done, snapshot}), 32'd0);
    repeat (3) @(negedge clock);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].n, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].poke);
      model_check(vecs[i].n, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
      check_output($sformatf("vec%0d_runs_done", i), 32'(runs_done), 32'(vecs[i].e_runs));
      check_output($sformatf("vec%0d_cycles", i), 32'(cycles), 32'(vecs[i].e_cycles));
      check_output($sformatf("vec%0d_total", i), 32'(total_cycles), 32'(vecs[i].e_total));
      check_output($sformatf("vec%0d_timeout", i), 32'(timeout_err), 32'(vecs[i].e_to));
    end

    // finished already high before the start: no rising edge, so the run must hang
    hold = 1'b1;
    repeat (2) @(negedge clock);
    apply_stimulus(1, 3, 0, 0, 0, 1'b0);
    model_check(1, NEVER, 0, 0, 0);
    hold = 1'b0;
    repeat (3) @(negedge clock);

    // asynchronous reset while waiting on the processor
    for (int i = 0; i < 8; i++) cur_delay[i] = NEVER;
    clear_monitor();
    @(negedge clock); #1;
    go = 1'b1;
    num_runs = RUNS_W'(2);
    @(negedge clock); #1;
    go = 1'b0;
    repeat (6) @(negedge clock);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_start", 32'(proc_start), 32'd0);
    check_output("midrst_counters", 32'({cycles, total_cycles, runs_done}), 32'd0);
    check_output("midrst_flags", 32'({snapshot, timeout_err, done, snap_valid}), 32'd0);
    repeat (2) @(negedge clock);
    #1 rst_n = 1'b1;
    done_count = 0;
    repeat (25) @(negedge clock);
    #1;
    check_output("midrst_no_done", 32'(done_count), 32'd0);
    check_output("midrst_idle", 32'(busy), 32'd0);
    m_cycles = 0;
    m_total = 0;
    m_snap = '0;
    apply_stimulus(1, 10, 0, 0, 0, 1'b0);
    model_check(1, 10, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      int n, d0, d1, d2, d3;
      bit poke;
      n = $urandom_range(0, 4);
      d0 = $urandom_range(0, 18);
      d1 = $urandom_range(0, 18);
      d2 = $urandom_range(0, 18);
      d3 = $urandom_range(0, 18);
      poke = 1'($urandom_range(0, 1));
      apply_stimulus(n, d0, d1, d2, d3, poke);
      model_check(n, d0, d1, d2, d3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
